// File: rtl/hazard3_aclint_pkg.sv
// Shared constants for the ACLINT machine timer: the register map and the APB handshake states.
package hazard3_aclint_pkg;

  localparam logic [15:0] MSIP_BASE     = 16'h0000;
  localparam logic [15:0] MTIMECMP_BASE = 16'h4000;
  localparam logic [15:0] MTIME_LO      = 16'hBFF8;
  localparam logic [15:0] MTIME_HI      = 16'hBFFC;
  localparam logic [15:0] CTRL_ADDR     = 16'hC000;
  localparam logic [15:0] DIV_ADDR      = 16'hC004;

  localparam int CTRL_EN = 0;

  typedef enum logic [1:0] {
    APB_IDLE,
    APB_WAIT,
    APB_RESP
  } apb_state_e;

endpackage

// File: rtl/hazard3_tick_sync.sv
// Converts the tick input into counting events (NRZ toggle or level strobe) and divides
// them by DIV+1, producing a single-cycle mtime increment pulse.
module hazard3_tick_sync #(
  parameter bit TICK_IS_NRZ = 1'b0,
  parameter int W_DIV       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tick,
  input  logic             i_en,
  input  logic             i_halt,
  input  logic             i_clr,
  input  logic [W_DIV-1:0] i_div,
  output logic             o_mtime_inc
);

  logic             w_event;
  logic             w_count_en;
  logic             w_wrap;
  logic [W_DIV-1:0] r_count;

  generate
    if (TICK_IS_NRZ) begin : g_nrz
      // [0],[1] synchronise; [2] holds the previous synchronised level for edge detect
      logic [2:0] r_sync;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sync <= '0;
        else        r_sync <= {r_sync[1:0], i_tick};
      end
      assign w_event = r_sync[1] ^ r_sync[2];
    end else begin : g_lvl
      assign w_event = i_tick;
    end
  endgenerate

  // Events seen while halted or disabled are simply dropped
  assign w_count_en  = w_event && i_en && !i_halt;
  assign w_wrap      = (r_count == i_div);
  assign o_mtime_inc = w_count_en && w_wrap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          r_count <= '0;
    else if (i_clr)      r_count <= '0;
    else if (w_count_en) r_count <= w_wrap ? '0 : r_count + 1'b1;
  end

endmodule

// File: rtl/hazard3_aclint_mtimer.sv
// ACLINT machine timer: shared 64-bit mtime, per-hart mtimecmp/msip, prescaled tick,
// and an APB slave with one wait state and error response on unmapped addresses.
module hazard3_aclint_mtimer
  import hazard3_aclint_pkg::*;
#(
  parameter int N_HARTS     = 2,
  parameter bit TICK_IS_NRZ = 1'b0,
  parameter int W_DIV       = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [15:0]        paddr,
  input  logic               psel,
  input  logic               penable,
  input  logic               pwrite,
  input  logic [31:0]        pwdata,
  output logic [31:0]        prdata,
  output logic               pready,
  output logic               pslverr,
  input  logic               dbg_halt,
  input  logic               tick,
  output logic [N_HARTS-1:0] soft_irq,
  output logic [N_HARTS-1:0] timer_irq
);

  apb_state_e          r_state, w_state_nxt;
  logic [31:0]         r_prdata;
  logic                r_pslverr;
  logic [63:0]         r_mtime;
  logic [63:0]         r_mtimecmp [N_HARTS];
  logic [N_HARTS-1:0]  r_msip;
  logic [N_HARTS-1:0]  r_timer_irq;
  logic                r_en;
  logic [W_DIV-1:0]    r_div;

  logic                w_acc, w_wr;
  logic [15:0]         w_word, w_off_msip, w_off_cmp;
  logic                w_is_msip, w_is_cmp;
  logic                w_hit;
  logic [31:0]         w_rdata;
  logic [N_HARTS-1:0]  w_sel_msip, w_sel_cmp_lo, w_sel_cmp_hi;
  logic                w_sel_mt_lo, w_sel_mt_hi, w_sel_ctrl, w_sel_div;
  logic                w_mtime_inc;
  logic                w_unused;

  assign w_unused = ^paddr[1:0];

  // ACCESS only counts after a SETUP cycle, so a held psel&penable cannot retrigger
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      APB_IDLE: if (psel && !penable) w_state_nxt = APB_WAIT;
      APB_WAIT: begin
        if (psel && penable) w_state_nxt = APB_RESP;
        else if (!psel)      w_state_nxt = APB_IDLE;
      end
      APB_RESP: w_state_nxt = APB_IDLE;
      default:  w_state_nxt = APB_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= APB_IDLE;
    else        r_state <= w_state_nxt;
  end

  assign w_acc   = (r_state == APB_WAIT) && psel && penable;
  assign w_wr    = w_acc && pwrite;
  assign pready  = (r_state == APB_RESP);
  assign prdata  = r_prdata;
  assign pslverr = r_pslverr;

  assign w_word     = {paddr[15:2], 2'b00};
  assign w_off_msip = w_word - MSIP_BASE;
  assign w_off_cmp  = w_word - MTIMECMP_BASE;
  assign w_is_msip  = w_off_msip < 16'(4 * N_HARTS);
  assign w_is_cmp   = w_off_cmp  < 16'(8 * N_HARTS);

  always_comb begin
    w_hit        = 1'b0;
    w_rdata      = '0;
    w_sel_msip   = '0;
    w_sel_cmp_lo = '0;
    w_sel_cmp_hi = '0;
    w_sel_mt_lo  = 1'b0;
    w_sel_mt_hi  = 1'b0;
    w_sel_ctrl   = 1'b0;
    w_sel_div    = 1'b0;
    if (w_is_msip) begin
      for (int h = 0; h < N_HARTS; h++) begin
        if (w_off_msip[5:2] == 4'(h)) begin
          w_hit         = 1'b1;
          w_sel_msip[h] = 1'b1;
          w_rdata       = {31'b0, r_msip[h]};
        end
      end
    end else if (w_is_cmp) begin
      for (int h = 0; h < N_HARTS; h++) begin
        if (w_off_cmp[6:3] == 4'(h)) begin
          w_hit = 1'b1;
          if (w_off_cmp[2]) begin
            w_sel_cmp_hi[h] = 1'b1;
            w_rdata         = r_mtimecmp[h][63:32];
          end else begin
            w_sel_cmp_lo[h] = 1'b1;
            w_rdata         = r_mtimecmp[h][31:0];
          end
        end
      end
    end else begin
      case (w_word)
        MTIME_LO:  begin w_hit = 1'b1; w_sel_mt_lo = 1'b1; w_rdata = r_mtime[31:0];  end
        MTIME_HI:  begin w_hit = 1'b1; w_sel_mt_hi = 1'b1; w_rdata = r_mtime[63:32]; end
        CTRL_ADDR: begin w_hit = 1'b1; w_sel_ctrl  = 1'b1; w_rdata = {31'b0, r_en};  end
        DIV_ADDR:  begin w_hit = 1'b1; w_sel_div   = 1'b1; w_rdata = 32'(r_div);     end
        default:   ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_prdata  <= '0;
      r_pslverr <= 1'b0;
    end else if (w_acc) begin
      r_prdata  <= w_rdata;
      r_pslverr <= !w_hit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en  <= 1'b1;
      r_div <= '0;
    end else begin
      if (w_wr && w_sel_ctrl) r_en  <= pwdata[CTRL_EN];
      if (w_wr && w_sel_div)  r_div <= pwdata[W_DIV-1:0];
    end
  end

  hazard3_tick_sync #(
    .TICK_IS_NRZ (TICK_IS_NRZ),
    .W_DIV       (W_DIV)
  ) u_tick_sync (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_tick      (tick),
    .i_en        (r_en),
    .i_halt      (dbg_halt),
    .i_clr       ((w_wr && w_sel_div) || !r_en),
    .i_div       (r_div),
    .o_mtime_inc (w_mtime_inc)
  );

  // A bus write to either half suppresses that cycle's increment entirely (no carry)
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    r_mtime <= '0;
    else if (w_wr && w_sel_mt_lo)  r_mtime[31:0]  <= pwdata;
    else if (w_wr && w_sel_mt_hi)  r_mtime[63:32] <= pwdata;
    else if (w_mtime_inc)          r_mtime <= r_mtime + 64'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int h = 0; h < N_HARTS; h++) r_mtimecmp[h] <= '1;
      r_msip      <= '0;
      r_timer_irq <= '0;
    end else begin
      for (int h = 0; h < N_HARTS; h++) begin
        if (w_wr && w_sel_cmp_lo[h]) r_mtimecmp[h][31:0]  <= pwdata;
        if (w_wr && w_sel_cmp_hi[h]) r_mtimecmp[h][63:32] <= pwdata;
        if (w_wr && w_sel_msip[h])   r_msip[h]            <= pwdata[0];
        r_timer_irq[h] <= (r_mtime >= r_mtimecmp[h]);
      end
    end
  end

  assign soft_irq  = r_msip;
  assign timer_irq = r_timer_irq;

endmodule

// File: tb/tb_hazard3_aclint_mtimer.sv
// Directed bench: a level-tick instance and an NRZ-tick instance share one APB bus,
// selected by separate psel lines; expectations are hand-computed constants.
module tb_hazard3_aclint_mtimer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] paddr = '0;
  logic [1:0]  psel = '0;
  logic        penable = 1'b0;
  logic        pwrite = 1'b0;
  logic [31:0] pwdata = '0;
  logic        dbg_halt = 1'b0;
  logic        tick0 = 1'b0;
  logic        tick1 = 1'b0;

  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1, pslverr0, pslverr1;
  logic [1:0]  sirq0, tirq0, sirq1, tirq1;

  int          nvec = 0;
  int          nerr = 0;
  logic [31:0] rd;
  logic        err;

  always #5 clk = ~clk;

  hazard3_aclint_mtimer #(.N_HARTS(2), .TICK_IS_NRZ(1'b0), .W_DIV(8)) u_lvl (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel[0]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata0), .pready(pready0),
    .pslverr(pslverr0), .dbg_halt(dbg_halt), .tick(tick0),
    .soft_irq(sirq0), .timer_irq(tirq0)
  );

  hazard3_aclint_mtimer #(.N_HARTS(2), .TICK_IS_NRZ(1'b1), .W_DIV(8)) u_nrz (
    .clk(clk), .rst_n(rst_n), .paddr(paddr), .psel(psel[1]), .penable(penable),
    .pwrite(pwrite), .pwdata(pwdata), .prdata(prdata1), .pready(pready1),
    .pslverr(pslverr1), .dbg_halt(dbg_halt), .tick(tick1),
    .soft_irq(sirq1), .timer_irq(tirq1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // SETUP, ACCESS (wait), RESP, then one cycle holding psel&penable to confirm no retrigger
  task automatic apb(input logic d, input logic wr, input logic [15:0] a, input logic [31:0] wd,
                     output logic [31:0] rdo, output logic erro);
    @(posedge clk); #1;
    psel    = d ? 2'b10 : 2'b01;
    penable = 1'b0;
    pwrite  = wr;
    paddr   = a;
    pwdata  = wd;
    @(posedge clk); #1;
    penable = 1'b1;
    chk("pready_wait", 64'(d ? pready1 : pready0), 64'd0);
    @(posedge clk); #1;
    chk("pready_resp", 64'(d ? pready1 : pready0), 64'd1);
    rdo  = d ? prdata1 : prdata0;
    erro = d ? pslverr1 : pslverr0;
    @(posedge clk); #1;
    chk("pready_after", 64'(d ? pready1 : pready0), 64'd0);
    psel    = '0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time bound");
    $fatal(1, "timeout");
  end

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pready",  64'(pready0),  64'd0);
    chk("rst_pslverr", 64'(pslverr0), 64'd0);
    chk("rst_prdata",  64'(prdata0),  64'd0);
    chk("rst_soft",    64'({sirq1, sirq0}), 64'd0);
    chk("rst_timer",   64'({tirq1, tirq0}), 64'd0);
    rst_n = 1'b1;

    apb(1'b0, 1'b0, 16'h4000, 32'h0, rd, err);
    chk("cmp0_lo_rst", 64'(rd), 64'hFFFF_FFFF);
    chk("cmp0_lo_err", 64'(err), 64'd0);
    apb(1'b0, 1'b0, 16'h4004, 32'h0, rd, err);
    chk("cmp0_hi_rst", 64'(rd), 64'hFFFF_FFFF);
    chk("cmp0_hi_err", 64'(err), 64'd0);
    chk("timer_after_rst", 64'(tirq0), 64'd0);

    // DIV=3, 16 level events -> 4 increments
    apb(1'b0, 1'b1, 16'hC004, 32'd3, rd, err);
    tick0 = 1'b1;
    repeat (16) @(posedge clk);
    #1 tick0 = 1'b0;
    apb(1'b0, 1'b0, 16'hBFF8, 32'h0, rd, err);
    chk("div3_lo", 64'(rd), 64'd4);
    apb(1'b0, 1'b0, 16'hBFFC, 32'h0, rd, err);
    chk("div3_hi", 64'(rd), 64'd0);

    // same with 8 of 16 cycles halted -> 2 increments
    apb(1'b0, 1'b1, 16'hBFF8, 32'd0, rd, err);
    apb(1'b0, 1'b1, 16'hC004, 32'd3, rd, err);
    tick0 = 1'b1;
    for (int i = 0; i < 16; i++) begin
      dbg_halt = (i >= 4) && (i <= 11);
      @(posedge clk); #1;
    end
    tick0 = 1'b0;
    dbg_halt = 1'b0;
    apb(1'b0, 1'b0, 16'hBFF8, 32'h0, rd, err);
    chk("halt_lo", 64'(rd), 64'd2);

    // mtimecmp[1]=5, count from 0 with DIV=0
    apb(1'b0, 1'b1, 16'hBFF8, 32'd0, rd, err);
    apb(1'b0, 1'b1, 16'hC004, 32'd0, rd, err);
    apb(1'b0, 1'b1, 16'h4008, 32'd5, rd, err);
    apb(1'b0, 1'b1, 16'h400C, 32'd0, rd, err);
    for (int k = 1; k <= 5; k++) begin
      tick0 = 1'b1;
      @(posedge clk); #1;
      tick0 = 1'b0;
      chk("timer_before5", 64'(tirq0), 64'd0);
    end
    @(posedge clk); #1;
    chk("timer_at5", 64'(tirq0), 64'b10);

    // wrap all-ones -> 0 with mtimecmp[0]=0
    apb(1'b0, 1'b1, 16'h4000, 32'd0, rd, err);
    apb(1'b0, 1'b1, 16'h4004, 32'd0, rd, err);
    apb(1'b0, 1'b1, 16'hBFF8, 32'hFFFF_FFFF, rd, err);
    apb(1'b0, 1'b1, 16'hBFFC, 32'hFFFF_FFFF, rd, err);
    tick0 = 1'b1;
    @(posedge clk); #1;
    tick0 = 1'b0;
    @(posedge clk); #1;
    chk("timer_wrap", 64'(tirq0), 64'b01);
    apb(1'b0, 1'b0, 16'hBFF8, 32'h0, rd, err);
    chk("wrap_lo", 64'(rd), 64'd0);
    apb(1'b0, 1'b0, 16'hBFFC, 32'h0, rd, err);
    chk("wrap_hi", 64'(rd), 64'd0);

    // msip and out-of-range hart
    apb(1'b0, 1'b1, 16'h0004, 32'h3, rd, err);
    chk("msip1_soft", 64'(sirq0), 64'b10);
    apb(1'b0, 1'b0, 16'h0004, 32'h0, rd, err);
    chk("msip1_rd", 64'(rd), 64'd1);
    chk("msip1_err", 64'(err), 64'd0);
    apb(1'b0, 1'b1, 16'h0008, 32'h1, rd, err);
    chk("msip2_wr_err", 64'(err), 64'd1);
    chk("msip2_soft", 64'(sirq0), 64'b10);
    apb(1'b0, 1'b0, 16'h0008, 32'h0, rd, err);
    chk("msip2_rd", 64'(rd), 64'd0);
    chk("msip2_rd_err", 64'(err), 64'd1);
    apb(1'b0, 1'b0, 16'h4010, 32'h0, rd, err);
    chk("cmp2_err", 64'(err), 64'd1);

    // EN cleared: ticks ignored
    apb(1'b0, 1'b1, 16'hC000, 32'h0, rd, err);
    apb(1'b0, 1'b0, 16'hC000, 32'h0, rd, err);
    chk("ctrl_rd", 64'(rd), 64'd0);
    tick0 = 1'b1;
    repeat (3) @(posedge clk);
    #1 tick0 = 1'b0;
    apb(1'b0, 1'b0, 16'hBFF8, 32'h0, rd, err);
    chk("en0_lo", 64'(rd), 64'd0);

    // NRZ: three asynchronous toggles -> 3 increments
    #17 tick1 = 1'b1;
    #23 tick1 = 1'b0;
    #31 tick1 = 1'b1;
    repeat (6) @(posedge clk);
    apb(1'b1, 1'b0, 16'hBFF8, 32'h0, rd, err);
    chk("nrz_lo", 64'(rd), 64'd3);

    // NRZ event lands on the MTIME lo write edge: write wins, no carry into hi
    apb(1'b1, 1'b1, 16'hBFF8, 32'hFFFF_FFFF, rd, err);
    @(posedge clk); #1;
    tick1 = ~tick1;
    apb(1'b1, 1'b1, 16'hBFF8, 32'h10, rd, err);
    repeat (5) @(posedge clk);
    apb(1'b1, 1'b0, 16'hBFF8, 32'h0, rd, err);
    chk("coll_lo", 64'(rd), 64'h10);
    apb(1'b1, 1'b0, 16'hBFFC, 32'h0, rd, err);
    chk("coll_hi", 64'(rd), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
